// File: rtl/alarm_pkg.sv
// Shared types and default widths for the alarm tone generator.
package alarm_pkg;

   localparam int DIV_W = 18;
   localparam int CAD_W = 27;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_OFF
   } state_t;

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Control/config/audio bundle of alarm_tone_gen; cfg_half2 exists only with ALARM_WARBLE_EN.
interface alarm_tone_gen_if #(
   parameter int DIV_W = alarm_pkg::DIV_W,
   parameter int CAD_W = alarm_pkg::CAD_W,
   parameter int CNT_W = alarm_pkg::CNT_W
);
   logic             cronofin;
   logic             stop;
   logic [DIV_W-1:0] cfg_half;
`ifdef ALARM_WARBLE_EN
   logic [DIV_W-1:0] cfg_half2;
`endif
   logic [CAD_W-1:0] cfg_on;
   logic [CAD_W-1:0] cfg_off;
   logic [CNT_W-1:0] cfg_beeps;
   logic             sonido;
   logic             busy;
   logic             done;

   modport master (
      output cronofin, stop, cfg_half, cfg_on, cfg_off, cfg_beeps,
`ifdef ALARM_WARBLE_EN
      output cfg_half2,
`endif
      input  sonido, busy, done
   );

   modport slave (
      input  cronofin, stop, cfg_half, cfg_on, cfg_off, cfg_beeps,
`ifdef ALARM_WARBLE_EN
      input  cfg_half2,
`endif
      output sonido, busy, done
   );

endinterface

// File: rtl/alarm_tone_gen_tone_div.sv
// Square-wave divider: toggles every max(half,1) enabled cycles; restart forces a high phase.
module tone_div #(
   parameter int DIV_W = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] half,
   input  logic             en,
   input  logic             restart,
   output logic             wave
);

   logic [DIV_W-1:0] cnt_reg;
   logic             wave_reg;
   logic [DIV_W-1:0] half_eff;
   logic             wrap;

   assign half_eff = (half == '0) ? DIV_W'(1) : half;
   assign wrap     = (cnt_reg == half_eff - DIV_W'(1));

   // When neither restarting nor enabled the output parks low (silence).
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg  <= '0;
         wave_reg <= 1'b0;
      end else if (restart) begin
         cnt_reg  <= '0;
         wave_reg <= 1'b1;
      end else if (en) begin
         if (wrap) begin
            cnt_reg  <= '0;
            wave_reg <= ~wave_reg;
         end else begin
            cnt_reg  <= cnt_reg + DIV_W'(1);
         end
      end else begin
         cnt_reg  <= '0;
         wave_reg <= 1'b0;
      end
   end

   assign wave = wave_reg;

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm beep cadence generator started by a cronofin rising edge.
// Optional two-tone warble on even beeps when ALARM_WARBLE_EN is defined.
module alarm_tone_gen
   import alarm_pkg::*;
#(
   parameter int DIV_W = alarm_pkg::DIV_W,
   parameter int CAD_W = alarm_pkg::CAD_W,
   parameter int CNT_W = alarm_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   alarm_tone_gen_if.slave  bus
);

   state_t           state_reg, state_next;
   logic             cronofin_q;
   logic [DIV_W-1:0] half_reg;
   logic [CAD_W-1:0] on_reg, off_reg;
   logic [CNT_W-1:0] beeps_reg;
   logic [CAD_W-1:0] cad_reg;
   logic [CNT_W-1:0] beep_reg;
   logic             done_reg;
`ifdef ALARM_WARBLE_EN
   logic [DIV_W-1:0] half2_reg;
   logic             par_reg;
`endif

   logic             start_edge, start, restart, en, beep_inc, done_next;
   logic [CAD_W-1:0] on_eff;
   logic             on_exp, off_exp, last;
   logic [DIV_W-1:0] tone_half;
   logic             wave;

   assign start_edge = bus.cronofin & ~cronofin_q;
   assign on_eff     = (on_reg == '0) ? CAD_W'(1) : on_reg;
   assign on_exp     = (cad_reg == on_eff - CAD_W'(1));
   assign off_exp    = (cad_reg == off_reg - CAD_W'(1));
   assign last       = (beeps_reg != '0) && (beep_reg == beeps_reg);

`ifdef ALARM_WARBLE_EN
   assign tone_half = par_reg ? half2_reg : half_reg;
`else
   assign tone_half = half_reg;
`endif

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      restart    = 1'b0;
      en         = 1'b0;
      beep_inc   = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start_edge) begin
               start      = 1'b1;
               restart    = 1'b1;
               state_next = ST_ON;
            end
         end
         ST_ON: begin
            if (!on_exp) begin
               en = 1'b1;
            end else if (last) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end else if (off_reg == '0) begin
               restart  = 1'b1;
               beep_inc = 1'b1;
            end else begin
               state_next = ST_OFF;
            end
         end
         ST_OFF: begin
            if (off_exp) begin
               state_next = ST_ON;
               restart    = 1'b1;
               beep_inc   = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // Abort overrides everything, including a simultaneous start edge.
      if (bus.stop) begin
         state_next = ST_IDLE;
         start      = 1'b0;
         restart    = 1'b0;
         en         = 1'b0;
         beep_inc   = 1'b0;
         done_next  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= ST_IDLE;
         cronofin_q <= 1'b1;
         done_reg   <= 1'b0;
         cad_reg    <= '0;
         beep_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         cronofin_q <= bus.cronofin;
         done_reg   <= done_next;
         if (restart || state_next == ST_IDLE || state_next != state_reg)
            cad_reg <= '0;
         else
            cad_reg <= cad_reg + CAD_W'(1);
         // Beep counter saturates so infinite mode never wraps.
         if (state_next == ST_IDLE)
            beep_reg <= '0;
         else if (start)
            beep_reg <= CNT_W'(1);
         else if (beep_inc && beep_reg != {CNT_W{1'b1}})
            beep_reg <= beep_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         half_reg  <= '0;
         on_reg    <= '0;
         off_reg   <= '0;
         beeps_reg <= '0;
      end else if (start) begin
         half_reg  <= bus.cfg_half;
         on_reg    <= bus.cfg_on;
         off_reg   <= bus.cfg_off;
         beeps_reg <= bus.cfg_beeps;
      end
   end

`ifdef ALARM_WARBLE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         half2_reg <= '0;
         par_reg   <= 1'b0;
      end else if (start) begin
         half2_reg <= bus.cfg_half2;
         par_reg   <= 1'b0;
      end else if (beep_inc) begin
         par_reg   <= ~par_reg;
      end
   end
`endif

   tone_div #(.DIV_W(DIV_W)) u_tone (
      .clk     (clk),
      .rst     (rst),
      .half    (tone_half),
      .en      (en),
      .restart (restart),
      .wave    (wave)
   );

   assign bus.sonido = wave;
   assign bus.busy   = (state_reg != ST_IDLE);
   assign bus.done   = done_reg;

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Parametrised alarm sound generator driven by the chronometer's finish flag. On a rising edge of `cronofin` it plays a programmable beep cadence: square-wave tone bursts separated by silent gaps, for a fixed number of beeps or until stopped. It drives `sonido` to the speaker pin and reports `busy`/`done` to the control FSM. It succeeds the fixed-tone audio block: runtime-programmable pitch, cadence and repeat count, explicit stop, and an optional two-tone warble.

## Interface
- `DIV_W`, 18, width of the tone half-period field and divider counter
- `CAD_W`, 27, width of the on/off cadence fields and counter
- `CNT_W`, 8, width of the beep-count field and counter
- `clk  in  1`  system clock; one clock domain.
- `rst  in  1`  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `cronofin  in  1`  chronometer finished; its rising edge starts an alarm.
- `stop  in  1`  synchronous abort.
- `cfg_half  in  DIV_W`  tone half-period in cycles; 0 is treated as 1.
- `cfg_half2  in  DIV_W`  second tone half-period; present only with `ALARM_WARBLE_EN`.
- `cfg_on  in  CAD_W`  beep length in cycles; 0 is treated as 1.
- `cfg_off  in  CAD_W`  gap length in cycles; 0 means no gap.
- `cfg_beeps  in  CNT_W`  number of beeps; 0 means repeat until `stop`.
- `sonido  out  1`  registered square-wave audio output.
- `busy  out  1`  high while the alarm is active (ON or OFF state).
- `done  out  1`  one-cycle pulse when a counted alarm completes.

## Operation
- States:
  - IDLE → ON on a `cronofin` rising edge (`cronofin & ~cronofin_q`).
  - ON → OFF when the ON counter expires, the alarm is not on its last beep, and `cfg_off != 0`.
  - ON → ON (next beep, counters cleared) when `cfg_off == 0` and the alarm is not on its last beep.
  - ON → IDLE when the last beep ends, with `done` = 1.
  - OFF → ON when the OFF counter expires.
- Last beep means `cfg_beeps != 0` and the beeps completed equal `cfg_beeps`. The final gap is skipped.
- All `cfg_*` inputs are latched on the start edge. Changes during an alarm are ignored.
- In ON, `sonido` starts at 1 on the first ON cycle and toggles every `cfg_half` cycles. Each beep restarts the phase at 1.
- `sonido` is 0 in IDLE and OFF.
- `stop` high: the block goes to IDLE in the next cycle from any state, `sonido` = 0, and no `done` pulse is issued.
- `stop` and a start edge in the same cycle: `stop` wins and no alarm starts.
- A `cronofin` edge while `busy` is ignored; the alarm does not restart.
- The beep counter saturates at its maximum in infinite mode (`cfg_beeps` = 0).
- Reset values:
  - state IDLE
  - `sonido` = 0, `busy` = 0, `done` = 0
  - all counters 0
  - `cronofin_q` = 1, so a level held high through reset does not start an alarm; a fresh rising edge is required.

## Timing
- Start edge seen in cycle k: ON runs cycles k+1 .. k+`cfg_on`, with `sonido` = 1 at k+1 and `busy` = 1 from k+1.
- Gap: cycles k+`cfg_on`+1 .. k+`cfg_on`+`cfg_off`.
- Completion: `done` = 1 and `busy` = 0 in the cycle after the final ON cycle. `busy` and `done` are never high together.
- `stop` seen in cycle j: `busy` = 0 and `sonido` = 0 from cycle j+1.
- Reset during an alarm: all outputs take their reset values in the next cycle.

## Configuration
- `ALARM_WARBLE_EN` defined: port `cfg_half2` exists and is latched with the other config. Even-numbered beeps (2nd, 4th, ...) use `cfg_half2`; odd-numbered beeps use `cfg_half`.
- `ALARM_WARBLE_EN` undefined: port `cfg_half2` is absent and every beep uses `cfg_half`.

## Structure
- Package `alarm_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_ON`, `ST_OFF`)
  - default widths `DIV_W`, `CAD_W`, `CNT_W`
- Sub-module `tone_div`:
  - inputs: `half`, `en`, `restart`
  - output: the registered square wave
  - behaviour: counts to `max(half, 1)` and toggles; `restart` forces the output to 1 and clears the count.
- The top level contains the edge detect, FSM, cadence counter and beep counter.

## Test plan
- Reset held with `cronofin` = 1, then released: `sonido`, `busy` and `done` stay 0 with no alarm; a 0→1 `cronofin` then starts one.
- `cfg_half` = 3, `cfg_on` = 12, `cfg_off` = 6, `cfg_beeps` = 2, edge at k:
  - `sonido` = 111000111000 over k+1..k+12, then 0 over k+13..k+18, then the pattern repeats over k+19..k+30.
  - `done` = 1 at k+31 only; `busy` = 1 over k+1..k+30.
- `cfg_beeps` = 0, `cfg_off` = 0, `cfg_half` = 1: continuous 1010... toggle; `stop` asserted at cycle j gives `busy` = 0 and `sonido` = 0 at j+1, and `done` never pulses.
- Second `cronofin` edge mid-alarm, and `cfg_half` changed mid-alarm: the waveform is identical to the unperturbed run.
- `stop` and a start edge in the same cycle: no alarm starts. Reset asserted mid-ON: all outputs 0 in the next cycle.
- With `ALARM_WARBLE_EN`, `cfg_half` = 2, `cfg_half2` = 4, `cfg_beeps` = 2: beep 1 toggles every 2 cycles, beep 2 every 4 cycles.
